// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: assembles din_valid-qualified bits into WIDTH-bit words behind a valid/ready output with one pending slot.
// Latency 1 clk from last frame bit to word_valid; bits arriving while a word is pending are dropped and flag overrun.
// Optional even-parity trailer bit per frame when SERIAL_DESER_PARITY_EN is defined.
module serial_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             parity_err
);

`ifdef SERIAL_DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {COLLECT, PEND} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt, sr_sh, done_word, word_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             valid_nxt, ovr_nxt, xfer, slot_free;

    assign xfer      = word_valid & word_ready;
    assign slot_free = ~word_valid | word_ready;

    always_comb begin
        if (MSB_FIRST) sr_sh = {sr[WIDTH-2:0], din};
        else           sr_sh = {din, sr[WIDTH-1:1]};
    end

`ifdef SERIAL_DESER_PARITY_EN
    // par accumulates data bits; once the frame completes it holds the parity result for the pending word
    logic par, par_nxt, perr_q, perr_nxt, done_par;
    assign done_word  = sr;
    assign done_par   = par ^ din;
    assign parity_err = perr_q;
`else
    assign done_word  = sr_sh;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        word_nxt  = word_out;
        valid_nxt = word_valid & ~word_ready;
        ovr_nxt   = overrun & ~ovr_clr;
`ifdef SERIAL_DESER_PARITY_EN
        par_nxt   = par;
        perr_nxt  = perr_q;
`endif
        case (state)
            COLLECT: begin
                if (din_valid) begin
                    if (cnt == LAST) begin
                        cnt_nxt = '0;
                        if (slot_free) begin
                            word_nxt  = done_word;
                            valid_nxt = 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                            perr_nxt  = done_par;
                            par_nxt   = 1'b0;
`endif
                        end else begin
                            sr_nxt    = done_word;
                            state_nxt = PEND;
`ifdef SERIAL_DESER_PARITY_EN
                            par_nxt   = done_par;
`endif
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                        sr_nxt  = sr_sh;
`ifdef SERIAL_DESER_PARITY_EN
                        par_nxt = par ^ din;
`endif
                    end
                end
            end
            PEND: begin
                // a bit on the releasing edge is still lost: sr is not free until after this edge
                if (din_valid) ovr_nxt = 1'b1;
                if (xfer) begin
                    word_nxt  = sr;
                    valid_nxt = 1'b1;
                    state_nxt = COLLECT;
`ifdef SERIAL_DESER_PARITY_EN
                    perr_nxt  = par;
                    par_nxt   = 1'b0;
`endif
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sr         <= sr_nxt;
            cnt        <= cnt_nxt;
            word_out   <= word_nxt;
            word_valid <= valid_nxt;
            overrun    <= ovr_nxt;
        end
    end

`ifdef SERIAL_DESER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par    <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par    <= par_nxt;
            perr_q <= perr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: an MSB-first and an LSB-first instance share stimulus; a scoreboard checks every delivered word.
module tb_serial_deser;

`ifdef SERIAL_DESER_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FR  = 9;
`else
    localparam bit PAR = 1'b0;
    localparam int FR  = 8;
`endif

    logic       clk = 1'b0;
    logic       rst, din, din_valid, word_ready, ovr_clr;
    logic [7:0] w0, w1;
    logic       v0, v1, o0, o1, p0, p1;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    always #5 clk = ~clk;

    serial_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .word_out(w0), .word_valid(v0), .word_ready(word_ready),
        .overrun(o0), .ovr_clr(ovr_clr), .parity_err(p0));

    serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .word_out(w1), .word_valid(v1), .word_ready(word_ready),
        .overrun(o1), .ovr_clr(ovr_clr), .parity_err(p1));

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Scoreboard: compare each handshake transfer against the oldest expected entry
    always @(negedge clk) begin
        if (!rst) begin
            if (v0 && word_ready) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_msb unexpected word got=%h", w0);
                end else begin
                    logic [8:0] e;
                    e = q0.pop_front();
                    if ({p0, w0} !== e) begin
                        n_err++;
                        $display("FAIL sb_msb got perr/word=%b/%h want=%b/%h", p0, w0, e[8], e[7:0]);
                    end
                end
            end
            if (v1 && word_ready) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_lsb unexpected word got=%h", w1);
                end else begin
                    logic [8:0] e;
                    e = q1.pop_front();
                    if ({p1, w1} !== e) begin
                        n_err++;
                        $display("FAIL sb_lsb got perr/word=%b/%h want=%b/%h", p1, w1, e[8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        din       = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit push, input bit skip_last, input bit gaps);
        logic [8:0] fr;
        fr = PAR ? {w, ^w} : {1'b0, w};
        if (push) begin
            q0.push_back({1'b0, w});
            q1.push_back({1'b0, rev8(w)});
        end
        for (int i = FR - 1; i >= (skip_last ? 1 : 0); i--) begin
            send_bit(fr[i]);
            if (gaps) idle(1);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        #1;
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain left=%0d/%0d want=0/0", name, q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; word_ready = 1'b0; ovr_clr = 1'b0;
        idle(2);
        n_cmp++;
        if ({v0, w0, o0, p0, v1, w1, o1, p1} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h want=0", {v0, w0, o0, p0, v1, w1, o1, p1});
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (v0 !== 1'b1 || w0 !== 8'hA5 || o0 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_first_cycle got v/w/o=%b/%h/%b want=1/a5/0", v0, w0, o0);
        end
        idle(1);
        n_cmp++;
        if (v0 !== 1'b0 || v1 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_one_cycle got v0/v1=%b/%b want=0/0", v0, v1);
        end
        drain("basic");
    endtask

    task automatic test_gaps();
        word_ready = 1'b1;
        send_word(8'hA5, 1'b1, 1'b0, 1'b1);
        send_word(8'h3C, 1'b1, 1'b0, 1'b1);
        send_word(8'h81, 1'b1, 1'b0, 1'b0);
        drain("gaps");
    endtask

    task automatic test_overrun();
        word_ready = 1'b0;
        send_word(8'h3C, 1'b1, 1'b0, 1'b0);
        send_word(8'hC3, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        n_cmp++;
        if (o0 !== 1'b1 || o1 !== 1'b1 || v0 !== 1'b1 || w0 !== 8'h3C) begin
            n_err++;
            $display("FAIL ovr_set got o0/o1/v/w=%b/%b/%b/%h want=1/1/1/3c", o0, o1, v0, w0);
        end
        word_ready = 1'b1;
        idle(1);
        n_cmp++;
        if (v0 !== 1'b1 || w0 !== 8'hC3) begin
            n_err++;
            $display("FAIL ovr_second got v/w=%b/%h want=1/c3", v0, w0);
        end
        idle(1);
        n_cmp++;
        if (v0 !== 1'b0 || o0 !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_empty got v/o=%b/%b want=0/1", v0, o0);
        end
        ovr_clr = 1'b1;
        idle(1);
        ovr_clr = 1'b0;
        n_cmp++;
        if (o0 !== 1'b0 || o1 !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear got o0/o1=%b/%b want=0/0", o0, o1);
        end
        drain("overrun");
    endtask

    task automatic test_back_to_back();
        logic [7:0] w2;
        w2 = 8'h34;
        word_ready = 1'b0;
        send_word(8'h12, 1'b1, 1'b0, 1'b0);
        send_word(w2, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (v0 !== 1'b1 || w0 !== 8'h12) begin
            n_err++;
            $display("FAIL b2b_hold got v/w=%b/%h want=1/12", v0, w0);
        end
        word_ready = 1'b1;
        send_bit(PAR ? ^w2 : w2[0]);
        n_cmp++;
        if (v0 !== 1'b1 || w0 !== 8'h34 || v1 !== 1'b1 || w1 !== rev8(w2)) begin
            n_err++;
            $display("FAIL b2b_no_bubble got v/w=%b/%h want=1/34", v0, w0);
        end
        idle(1);
        n_cmp++;
        if (v0 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end got v=%b want=0", v0);
        end
        drain("b2b");
    endtask

    task automatic test_async_reset();
        word_ready = 1'b0;
        send_word(8'h77, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({v0, w0, o0, p0, v1, w1, o1, p1} !== 22'd0) begin
            n_err++;
            $display("FAIL async_reset got=%h want=0", {v0, w0, o0, p0, v1, w1, o1, p1});
        end
        idle(1);
        rst = 1'b0;
        word_ready = 1'b1;
        send_word(8'h5A, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (v0 !== 1'b1 || w0 !== 8'h5A) begin
            n_err++;
            $display("FAIL after_reset got v/w=%b/%h want=1/5a", v0, w0);
        end
        drain("reset");
    endtask

`ifdef SERIAL_DESER_PARITY_EN
    task automatic test_parity();
        logic [7:0] w;
        w = 8'hA5;
        word_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q0.push_back({1'(k), w});
            q1.push_back({1'(k), rev8(w)});
            for (int i = 7; i >= 0; i--) send_bit(w[i]);
            send_bit(1'(k));
            n_cmp++;
            if (v0 !== 1'b1 || w0 !== 8'hA5 || p0 !== 1'(k)) begin
                n_err++;
                $display("FAIL parity_%0d got v/w/perr=%b/%h/%b want=1/a5/%0d", k, v0, w0, p0, k);
            end
        end
        drain("parity");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_async_reset();
`ifdef SERIAL_DESER_PARITY_EN
        test_parity();
`endif
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
